// File: rtl/rv32i_pkg.sv
// Shared RV32I backend types: ALU opcodes, writeback payload and sizing constants.
package rv32i_pkg;

    localparam int unsigned RV_XLEN              = 32;
    localparam int unsigned PHYS_REG_FILE_IDX_BW = 6;
    localparam int unsigned ROB_DEPTH            = 16;
    localparam int unsigned ROB_IDX_BW           = $clog2(ROB_DEPTH);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    // Result plus the bookkeeping the CDB needs to route it.
    typedef struct packed {
        logic [RV_XLEN-1:0]              result;
        logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
        logic [ROB_IDX_BW-1:0]           rob_idx;
    } alu_pipe_payload_t;

endpackage

// File: rtl/rv32i_alu_core.sv
// Combinational RV32I integer ALU: add/sub, signed/unsigned compare, logic and shifts.
module rv32i_alu_core
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = b[ShW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_alu_pipe.sv
// Elastic pipelined ALU functional unit: computes in stage 0, delays through the remaining
// stages with per-stage valid/ready so bubbles collapse, and supports a full flush.
module rv32i_alu_pipe
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_vld,
    input  alu_op_e                         i_op,
    input  logic [XLEN-1:0]                 i_a,
    input  logic [XLEN-1:0]                 i_b,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_dst_phys_rf_tag,
    input  logic [ROB_IDX_BW-1:0]           i_rob_entry_idx,
    input  logic                            i_flush,
    input  logic                            i_rdy,
    output logic                            o_rdy,
    output logic                            o_vld,
    output logic [XLEN-1:0]                 o_result,
    output logic [PHYS_REG_FILE_IDX_BW-1:0] o_dst_phys_rf_tag,
    output logic [ROB_IDX_BW-1:0]           o_rob_entry_idx,
    output logic                            o_busy
);

    localparam int unsigned Last = PIPE_STAGES - 1;

    typedef struct packed {
        logic [XLEN-1:0]                 result;
        logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
        logic [ROB_IDX_BW-1:0]           rob_idx;
    } payload_t;

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] rdy;
    payload_t               pay [PIPE_STAGES];

    logic            accept;
    logic [XLEN-1:0] core_result;
    payload_t        in_pay;

    rv32i_alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .op     (i_op),
        .a      (i_a),
        .b      (i_b),
        .result (core_result)
    );

    assign in_pay = '{result: core_result, tag: i_dst_phys_rf_tag, rob_idx: i_rob_entry_idx};
    assign o_rdy  = rdy[0] & ~i_flush;
    assign accept = i_vld & o_rdy;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic     up_vld;
        payload_t up_pay;
        logic     vld_q;
        payload_t pay_q;

        if (s == 0) begin : g_head
            assign up_vld = accept;
            assign up_pay = in_pay;
        end else begin : g_body
            assign up_vld = vld[s-1];
            assign up_pay = pay[s-1];
        end

        // Unrolled form of rdy[s] = ~vld[s] | rdy[s+1]: ready if any stage from here down is
        // empty, or the sink takes the head this cycle.
        assign rdy[s] = i_rdy | ~(&vld[Last:s]);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q <= 1'b0;
                pay_q <= '0;
            end else if (i_flush) begin
                vld_q <= 1'b0;
            end else if (rdy[s]) begin
                vld_q <= up_vld;
                if (up_vld) begin
                    pay_q <= up_pay;
                end
            end
        end

        assign vld[s] = vld_q;
        assign pay[s] = pay_q;
    end

    assign o_vld             = vld[Last];
    assign o_result          = pay[Last].result;
    assign o_dst_phys_rf_tag = pay[Last].tag;
    assign o_rob_entry_idx   = pay[Last].rob_idx;
    assign o_busy            = |vld;

endmodule
